// File: rtl/floo_axi_test_endpoint.sv
// floo_axi_test_endpoint
//   Protocol-correct AXI4 subordinate for NoC chimneys without a cluster.
//   Writes: AW IDs are queued, W beats are discarded, and one B is returned per
//   burst once its last W beat has been accepted.
//   Reads: every AR burst is answered with data equal to the beat address
//   (start address + beat * bytes-per-beat, computed modulo 2^AddrWidth).
//   Responses are OKAY, or DECERR when RespErr != 0.
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   aw_*, w_*, b_*  : write channels (IDs only, data discarded)
//   ar_*, r_*       : read channels (INCR, full-width, aligned bursts)
//   wr_done_o       : completed B handshakes (wraps)
//   rd_done_o       : completed last-R handshakes (wraps)

// Registered FIFO: a push becomes visible at the head one cycle later.
module floo_axi_test_endpoint_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module floo_axi_test_endpoint #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTxns   = 4,
  parameter int unsigned RespErr   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [31:0]          wr_done_o,
  output logic [31:0]          rd_done_o
);
  localparam logic [1:0]  Resp      = (RespErr != 0) ? 2'b11 : 2'b00;
  localparam int unsigned BeatShift = $clog2(DataWidth / 8);
  localparam int unsigned ArWidth   = IdWidth + AddrWidth + 8;

  // Set while rst_i is sampled high so that readies read 0 during reset even
  // though the FIFOs are already empty.
  logic in_reset_q;

  logic               aw_empty, aw_full, b_empty, b_full, ar_empty, ar_full;
  logic [IdWidth-1:0] aw_head, b_head;
  logic [ArWidth-1:0] ar_head;

  logic [IdWidth-1:0]   ar_head_id;
  logic [AddrWidth-1:0] ar_head_addr;
  logic [7:0]           ar_head_len;

  logic                 aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last;
  logic [7:0]           beat_q;
  logic [AddrWidth-1:0] beat_addr;
  logic [31:0]          wr_done_q, rd_done_q;

  always_ff @(posedge clk_i) begin
    in_reset_q <= rst_i;
  end

  // Write path
  assign aw_ready_o = !aw_full && !in_reset_q;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_ready_o  = !aw_empty && !b_full && !in_reset_q;
  assign w_last_hs  = w_valid_i && w_ready_o && w_last_i;

  floo_axi_test_endpoint_fifo #(.Width(IdWidth), .Depth(MaxTxns)) i_aw_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (aw_hs),
    .data_i  (aw_id_i),
    .pop_i   (w_last_hs),
    .data_o  (aw_head),
    .empty_o (aw_empty),
    .full_o  (aw_full)
  );

  floo_axi_test_endpoint_fifo #(.Width(IdWidth), .Depth(MaxTxns)) i_b_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_last_hs),
    .data_i  (aw_head),
    .pop_i   (b_hs),
    .data_o  (b_head),
    .empty_o (b_empty),
    .full_o  (b_full)
  );

  assign b_valid_o = !b_empty;
  assign b_hs      = b_valid_o && b_ready_i;
  assign b_id_o    = b_valid_o ? b_head : '0;
  assign b_resp_o  = b_valid_o ? Resp : '0;

  // Read path
  assign ar_ready_o = !ar_full && !in_reset_q;
  assign ar_hs      = ar_valid_i && ar_ready_o;

  floo_axi_test_endpoint_fifo #(.Width(ArWidth), .Depth(MaxTxns)) i_ar_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ar_hs),
    .data_i  ({ar_id_i, ar_addr_i, ar_len_i}),
    .pop_i   (r_hs && r_last),
    .data_o  (ar_head),
    .empty_o (ar_empty),
    .full_o  (ar_full)
  );

  assign {ar_head_id, ar_head_addr, ar_head_len} = ar_head;

  assign r_valid_o = !ar_empty;
  assign r_last    = (beat_q == ar_head_len);
  assign r_hs      = r_valid_o && r_ready_i;
  assign beat_addr = ar_head_addr + (AddrWidth'(beat_q) << BeatShift);

  assign r_id_o   = r_valid_o ? ar_head_id : '0;
  assign r_data_o = r_valid_o ? DataWidth'(beat_addr) : '0;
  assign r_resp_o = r_valid_o ? Resp : '0;
  assign r_last_o = r_valid_o && r_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q    <= '0;
      wr_done_q <= '0;
      rd_done_q <= '0;
    end else begin
      if (b_hs) wr_done_q <= wr_done_q + 32'd1;
      if (r_hs) begin
        if (r_last) begin
          beat_q    <= '0;
          rd_done_q <= rd_done_q + 32'd1;
        end else begin
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

  assign wr_done_o = wr_done_q;
  assign rd_done_o = rd_done_q;
endmodule

// File: tb/tb_floo_axi_test_endpoint.sv
module tb_floo_axi_test_endpoint;
  localparam int IW = 4;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          aw_valid = 0, w_valid = 0, w_last = 0, b_ready = 1;
  logic          ar_valid = 0, r_ready = 1;
  logic [IW-1:0] aw_id = '0, ar_id = '0;
  logic [AW-1:0] ar_addr = '0;
  logic [7:0]    ar_len = '0;

  logic          aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic [IW-1:0] b_id, r_id;
  logic [1:0]    b_resp, r_resp;
  logic [DW-1:0] r_data;
  logic [31:0]   wr_done, rd_done;

  logic          e_aw_ready, e_w_ready, e_b_valid, e_ar_ready, e_r_valid, e_r_last;
  logic [IW-1:0] e_b_id, e_r_id;
  logic [1:0]    e_b_resp, e_r_resp;
  logic [DW-1:0] e_r_data;
  logic [31:0]   e_wr_done, e_rd_done;

  floo_axi_test_endpoint #(
    .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .MaxTxns(N), .RespErr(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
    .ar_addr_i(ar_addr), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .wr_done_o(wr_done), .rd_done_o(rd_done)
  );

  // Error-response build driven by the same stimulus.
  floo_axi_test_endpoint #(
    .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .MaxTxns(N), .RespErr(1)
  ) dut_err (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(e_aw_ready), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(e_w_ready), .w_last_i(w_last),
    .b_valid_o(e_b_valid), .b_ready_i(b_ready), .b_id_o(e_b_id), .b_resp_o(e_b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(e_ar_ready), .ar_id_i(ar_id),
    .ar_addr_i(ar_addr), .ar_len_i(ar_len),
    .r_valid_o(e_r_valid), .r_ready_i(r_ready), .r_id_o(e_r_id), .r_data_o(e_r_data),
    .r_resp_o(e_r_resp), .r_last_o(e_r_last),
    .wr_done_o(e_wr_done), .rd_done_o(e_rd_done)
  );

  int errors = 0;
  int checks = 0;
  int r_seen = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } r_t;

  logic [IW-1:0] aw_model[$];
  logic [IW-1:0] b_exp[$];
  r_t            r_exp[$];
  logic          r_stall, b_stall;
  r_t            r_prev;
  logic [IW-1:0] b_prev;

  // Scoreboard: expectations are pushed on request handshakes and popped on
  // response handshakes; stalled outputs are checked for stability.
  always @(negedge clk) begin
    if (rst) begin
      aw_model.delete();
      b_exp.delete();
      r_exp.delete();
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (r_stall) begin
        checks++;
        if (!r_valid || r_t'{id: r_id, data: r_data, last: r_last} !== r_prev) begin
          errors++;
          $display("FAIL r_stable: got v=%0b id=%0h data=%0h last=%0b, expected id=%0h data=%0h last=%0b",
                   r_valid, r_id, r_data, r_last, r_prev.id, r_prev.data, r_prev.last);
        end
      end
      if (b_stall) begin
        checks++;
        if (!b_valid || b_id !== b_prev) begin
          errors++;
          $display("FAIL b_stable: got v=%0b id=%0h, expected id=%0h", b_valid, b_id, b_prev);
        end
      end
      r_stall = r_valid && !r_ready;
      r_prev  = r_t'{id: r_id, data: r_data, last: r_last};
      b_stall = b_valid && !b_ready;
      b_prev  = b_id;

      if (b_valid && b_ready) begin
        checks++;
        if (b_exp.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got id=%0h, expected no B", b_id);
        end else begin
          logic [IW-1:0] eid;
          eid = b_exp.pop_front();
          if (b_id !== eid || b_resp !== 2'b00 || e_b_resp !== 2'b11 || !e_b_valid) begin
            errors++;
            $display("FAIL b_beat: got id=%0h resp=%0b err_resp=%0b, expected id=%0h resp=00 err_resp=11",
                     b_id, b_resp, e_b_resp, eid);
          end
        end
      end

      if (r_valid && r_ready) begin
        r_seen++;
        checks++;
        if (r_exp.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got id=%0h data=%0h, expected no R", r_id, r_data);
        end else begin
          r_t e;
          e = r_exp.pop_front();
          if (r_t'{id: r_id, data: r_data, last: r_last} !== e || r_resp !== 2'b00 ||
              e_r_resp !== 2'b11 || !e_r_valid) begin
            errors++;
            $display("FAIL r_beat: got id=%0h data=%0h last=%0b resp=%0b err_resp=%0b, expected id=%0h data=%0h last=%0b resp=00 err_resp=11",
                     r_id, r_data, r_last, r_resp, e_r_resp, e.id, e.data, e.last);
          end
        end
      end

      if (aw_valid && aw_ready) aw_model.push_back(aw_id);
      if (w_valid && w_ready && w_last && aw_model.size() != 0)
        b_exp.push_back(aw_model.pop_front());
      if (ar_valid && ar_ready) begin
        for (int i = 0; i <= int'(ar_len); i++) begin
          logic [AW-1:0] a;
          a = ar_addr + AW'(i) * AW'(DW / 8);
          r_exp.push_back(r_t'{id: ar_id, data: DW'(a), last: (i == int'(ar_len))});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b0 || wr_done !== 0 || rd_done !== 0 ||
        b_id !== '0 || r_id !== '0 || r_data !== '0 || r_last !== 1'b0 || b_resp !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got awr=%0b arr=%0b wr=%0b bv=%0b rv=%0b wd=%0d rd=%0d, expected all 0",
               aw_ready, ar_ready, w_ready, b_valid, r_valid, wr_done, rd_done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000 || wr_done !== 0 || rd_done !== 0) begin
      errors++;
      $display("FAIL idle_outputs: got awr=%0b arr=%0b wr=%0b bv=%0b rv=%0b wd=%0d rd=%0d, expected 1 1 0 0 0 0 0",
               aw_ready, ar_ready, w_ready, b_valid, r_valid, wr_done, rd_done);
    end
    step();
  endtask

  task automatic test_write();
    b_ready = 1'b1;
    w_valid = 1'b1;
    w_last  = 1'b0;
    aw_valid = 1'b1;
    aw_id    = 4'd3;
    @(negedge clk);
    checks++;
    if (w_ready !== 1'b0) begin
      errors++;
      $display("FAIL w_before_aw: got w_ready=%0b, expected 0", w_ready);
    end
    step();
    aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_last = (i == 3);
      @(negedge clk);
      checks++;
      if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
        errors++;
        $display("FAIL w_beat%0d: got w_ready=%0b b_valid=%0b, expected 1 0", i, w_ready, b_valid);
      end
      step();
    end
    w_valid = 1'b0;
    w_last  = 1'b0;
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b1 || b_id !== 4'd3 || b_resp !== 2'b00) begin
      errors++;
      $display("FAIL b_latency: got v=%0b id=%0h resp=%0b, expected 1 3 00", b_valid, b_id, b_resp);
    end
    step();
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b0 || wr_done !== 32'd1) begin
      errors++;
      $display("FAIL wr_done: got b_valid=%0b wr_done=%0d, expected 0 1", b_valid, wr_done);
    end
    step();
  endtask

  task automatic test_read();
    logic [DW-1:0] exp_data;
    r_ready  = 1'b1;
    ar_valid = 1'b1;
    ar_id    = 4'd5;
    ar_addr  = 48'h1000;
    ar_len   = 8'd3;
    step();
    ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data = 64'h1000 + 64'(i * 8);
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_id !== 4'd5 || r_data !== exp_data || r_last !== (i == 3)) begin
        errors++;
        $display("FAIL read_beat%0d: got v=%0b id=%0h data=%0h last=%0b, expected 1 5 %0h %0b",
                 i, r_valid, r_id, r_data, r_last, exp_data, (i == 3));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || rd_done !== 32'd1) begin
      errors++;
      $display("FAIL rd_done: got r_valid=%0b rd_done=%0d, expected 0 1", r_valid, rd_done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0;
    rd0 = rd_done;
    r_ready = 1'b0;
    b_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ar_valid = 1'b1;
      ar_id    = IW'(k);
      ar_addr  = 48'h2000 + 48'(k * 'h100);
      ar_len   = 8'(k % 3);
      @(negedge clk);
      checks++;
      if (ar_ready !== (k < N)) begin
        errors++;
        $display("FAIL ar_full%0d: got ar_ready=%0b, expected %0b", k, ar_ready, (k < N));
      end
      step();
    end
    r_ready = 1'b1;
    // Bursts of 1,2,3,1 beats are queued; the 5th (2 beats) enters after the first pop.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1) begin
        errors++;
        $display("FAIL r_gap%0d: got r_valid=%0b, expected 1", i, r_valid);
      end
      if (i < 2) begin
        checks++;
        if (ar_ready !== (i == 1)) begin
          errors++;
          $display("FAIL ar_after_pop%0d: got ar_ready=%0b, expected %0b", i, ar_ready, (i == 1));
        end
      end
      step();
      if (i == 1) ar_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || rd_done !== rd0 + 32'd5) begin
      errors++;
      $display("FAIL b2b_done: got r_valid=%0b rd_done=%0d, expected 0 %0d", r_valid, rd_done, rd0 + 5);
    end
    step();
  endtask

  task automatic test_stall();
    logic [31:0] rd0, wr0;
    int          seen0;
    int          cyc;
    rd0 = rd_done;
    wr0 = wr_done;
    seen0 = r_seen;
    r_ready  = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b1;
    ar_id    = 4'd7;
    ar_addr  = 48'hFFFF_FFFF_FF00;  // wraps past 2^48 mid-burst
    ar_len   = 8'd255;
    aw_valid = 1'b1;
    aw_id    = 4'd9;
    step();
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_last   = 1'b1;
    step();
    w_valid = 1'b0;
    w_last  = 1'b0;
    cyc = 0;
    while ((rd_done != rd0 + 32'd1 || wr_done != wr0 + 32'd1) && cyc < 4000) begin
      r_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    r_ready = 1'b1;
    b_ready = 1'b1;
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL stall_timeout: got rd_done=%0d wr_done=%0d, expected %0d %0d",
               rd_done, wr_done, rd0 + 1, wr0 + 1);
    end
    checks++;
    if (r_seen - seen0 != 256 || r_exp.size() != 0 || b_exp.size() != 0) begin
      errors++;
      $display("FAIL stall_beats: got beats=%0d pending_r=%0d pending_b=%0d, expected 256 0 0",
               r_seen - seen0, r_exp.size(), b_exp.size());
    end
  endtask

  task automatic test_reset_mid();
    r_ready  = 1'b1;
    b_ready  = 1'b0;
    ar_valid = 1'b1;
    ar_id    = 4'd2;
    ar_addr  = 48'h3000;
    ar_len   = 8'd20;
    aw_valid = 1'b1;
    aw_id    = 4'd1;
    step();
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_last   = 1'b1;
    step();
    w_valid = 1'b0;
    w_last  = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || b_valid !== 1'b0 || rd_done !== 0 || wr_done !== 0 ||
        e_r_valid !== 1'b0 || e_b_valid !== 1'b0 || aw_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rv=%0b bv=%0b rd=%0d wd=%0d awr=%0b, expected 0 0 0 0 0",
               r_valid, b_valid, rd_done, wr_done, aw_ready);
    end
    step();
    rst = 1'b0;
    b_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || b_valid !== 1'b0 || rd_done !== 0 || wr_done !== 0 || aw_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_stale: got rv=%0b bv=%0b rd=%0d wd=%0d awr=%0b, expected 0 0 0 0 1",
               r_valid, b_valid, rd_done, wr_done, aw_ready);
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/floo_axi_test_endpoint.md
Name: floo_axi_test_endpoint

Overview:
- Parametrised successor to the blank cluster wrapper used for synthesis and NoC testing.
- Replaces the all-zero tie-offs with a protocol-correct AXI4 subordinate.
- Accepts writes, discards data and returns B; answers reads with a deterministic address pattern.
- Placed at a NoC chimney wherever a full cluster is absent, so traffic completes instead of hanging.

Parameters:
- IdWidth, 4, AXI ID width.
- AddrWidth, 48, AXI address width.
- DataWidth, 64, AXI data width; power of two, ≥ 8.
- MaxTxns, 4, depth of each of the AW, B and AR FIFOs (outstanding transactions per direction); ≥ 2.
- RespErr, 0: 0 returns OKAY (2'b00); 1 returns DECERR (2'b11) on every B and R.

Ports:
- clk_i, in, 1, clock; all logic on the rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- aw_valid_i / aw_ready_o, in/out, 1 each, AW handshake.
- aw_id_i, in, IdWidth, write ID.
- w_valid_i / w_ready_o, in/out, 1 each, W handshake.
- w_last_i, in, 1, last write beat.
- b_valid_o / b_ready_i, out/in, 1 each, B handshake.
- b_id_o, out, IdWidth, response ID.
- b_resp_o, out, 2, response code.
- ar_valid_i / ar_ready_o, in/out, 1 each, AR handshake.
- ar_id_i, in, IdWidth, read ID.
- ar_addr_i, in, AddrWidth, burst start address (INCR, size = DataWidth/8, aligned).
- ar_len_i, in, 8, beats minus one.
- r_valid_o / r_ready_i, out/in, 1 each, R handshake.
- r_id_o, out, IdWidth, read ID.
- r_data_o, out, DataWidth, read data.
- r_resp_o, out, 2, response code.
- r_last_o, out, 1, last read beat.
- wr_done_o, out, 32, count of completed B handshakes; wraps.
- rd_done_o, out, 32, count of completed last-R handshakes; wraps.

Behaviour:
- Reset: all FIFOs are emptied and the beat counter cleared. Outputs go to valid = 0, ready = 0, id/data/resp/last = 0 and counters = 0 in the cycle after rst_i is sampled high.
- Reset mid-burst: in-flight transactions are dropped without responses, and no B or R is issued for them after reset.
- FIFOs are registered. A push is visible at the head in the next cycle. There is no same-cycle pass-through.
- Ready signals depend only on the full flag: a full FIFO deasserts ready even when a pop occurs in the same cycle.
- AW:
  - aw_ready_o = !aw_fifo_full.
  - On handshake, aw_id is pushed.
  - AW may precede W by up to MaxTxns bursts.
- W:
  - w_ready_o = !aw_fifo_empty && !b_fifo_full.
  - Beats are discarded.
  - A W beat presented before its AW is held off (w_ready_o = 0).
  - A handshake with w_last_i = 1 pops the AW head and pushes its ID to the B FIFO in the same cycle.
- B:
  - b_valid_o = !b_fifo_empty.
  - b_id_o = B head; b_resp_o = RespErr ? 2'b11 : 2'b00.
  - Pop and wr_done_o++ on handshake.
  - Minimum latency from the w_last handshake to b_valid_o is 1 cycle.
- AR:
  - ar_ready_o = !ar_fifo_full.
  - On handshake, {id, addr, len} are pushed.
- R engine:
  - r_valid_o = !ar_fifo_empty; fields are driven from the head plus the beat counter `beat` (8 bit).
  - r_data_o = (head.addr + beat*(DataWidth/8)), zero-extended or truncated to DataWidth. The sum is computed in AddrWidth bits and wraps modulo 2^AddrWidth.
  - r_last_o = (beat == head.len); r_id_o = head.id; r_resp_o matches b_resp_o.
  - On handshake: if last, pop, set beat = 0 and rd_done_o++; otherwise beat++.
  - Bursts are served back-to-back in AR order with no bubble.
  - First R beat is 1 cycle after the AR handshake.
- While r_ready_i = 0, all R outputs hold stable.
- While b_ready_i = 0, all B outputs hold stable.
- Read and write paths are fully independent and may complete in the same cycle.

Test Plan:
- Reset then idle → aw/ar_ready = 1, w_ready = 0, b/r_valid = 0, counters = 0.
- AW id=3, then 4 W beats with last on the 4th → exactly one B: id=3, resp=00, 1 cycle after the last W; wr_done = 1.
- AR id=5, addr=0x1000, len=3, r_ready tied 1 → 4 consecutive beats with data 0x1000, 0x1008, 0x1010, 0x1018; last on the 4th; rd_done = 1.
- Issue 5 ARs with b/r_ready = 0 and MaxTxns = 4 → ar_ready drops after the 4th. Release r_ready → bursts return in order with no gaps between bursts; the 5th AR is accepted after the first pop.
- Random r_ready/b_ready stalls during a len=255 burst → outputs stable while stalled, 256 beats, last only on beat 255.
- RespErr = 1 build → every B and R carries resp = 11. rst_i asserted mid-burst → valids are 0 next cycle and no stale beats follow.
